// File: rtl/bbox_pkg.sv
// Shared types for the bounding-box detector and the rectangle overlay stage.
package bbox_pkg;

  localparam int COORD_W    = 10;
  localparam int CNT_W      = 19;
  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  // Packed bounds as consumed on iRow/iCol: {max[19:10], min[9:0]}
  typedef struct packed {
    coord_t max;
    coord_t min;
  } bounds_t;

  // ST_SCAN doubles as the "armed" flag
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  function automatic bounds_t pack_bounds(input coord_t mx, input coord_t mn);
    bounds_t b;
    b.max = mx;
    b.min = mn;
    return b;
  endfunction

endpackage

// File: rtl/bbox_detect_if.sv
// Pixel stream in, published bounding box out.
interface bbox_detect_if;
  import bbox_pkg::*;

  logic         en;
  coord_t       Row;
  coord_t       Col;
  logic [9:0]   GRAY2BW;
  bounds_t      oRow;
  bounds_t      oCol;
  logic         oValid;
  logic         oEmpty;
  cnt_t         oCount;

  modport master (
    output en, Row, Col, GRAY2BW,
    input  oRow, oCol, oValid, oEmpty, oCount
  );

  modport slave (
    input  en, Row, Col, GRAY2BW,
    output oRow, oCol, oValid, oEmpty, oCount
  );
endinterface

// File: rtl/bbox_detect_minmax_track.sv
// Running min/max of one coordinate over the foreground pixels of a frame.
module minmax_track
  import bbox_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  input  logic   load_i,   // frame start: restart from this pixel alone
  input  logic   upd_i,    // mid-frame active sample
  input  logic   fg_i,
  input  coord_t val_i,
  output coord_t min_o,
  output coord_t max_o
);

  coord_t min_q, min_d;
  coord_t max_q, max_d;

  // Next min/max: reload on frame start, otherwise widen on foreground
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (load_i) begin
      min_d = fg_i ? val_i : '1;
      max_d = fg_i ? val_i : '0;
    end else if (upd_i && fg_i) begin
      if (val_i < min_q) min_d = val_i;
      if (val_i > max_q) max_d = val_i;
    end
  end

  // Min/max registers; empty-range values out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_q <= '1;
      max_q <= '0;
    end else if (en_i) begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;

endmodule

// File: rtl/bbox_detect.sv
// Scans a binarised frame, publishes the foreground bounding box one clock
// after the last active pixel and holds it for the whole next frame.
module bbox_detect
  import bbox_pkg::*;
#(
  parameter int         WIDTH     = DEF_WIDTH,
  parameter int         HEIGHT    = DEF_HEIGHT,
  parameter logic [9:0] FG_VALUE  = 10'd0,
  parameter int         MIN_COUNT = 16
) (
  input logic          clk,
  input logic          rst,
  bbox_detect_if.slave bus
);

  localparam coord_t W_LIM    = coord_t'(WIDTH);
  localparam coord_t H_LIM    = coord_t'(HEIGHT);
  localparam coord_t LAST_COL = coord_t'(WIDTH - 1);
  localparam coord_t LAST_ROW = coord_t'(HEIGHT - 1);
  localparam cnt_t   MIN_CNT  = cnt_t'(MIN_COUNT);

  logic   active, start, last, fg;
  state_e state_q, state_d;
  logic   acc_load, acc_upd, pub_d;
  logic   pub_q;
  cnt_t   cnt_q, cnt_d;
  coord_t rmin, rmax, cmin, cmax;

  bounds_t oRow_q, oCol_q;
  cnt_t    oCount_q;
  logic    oValid_q, oEmpty_q;

  // Blanking positions are never active
  assign active = (bus.Row < H_LIM) && (bus.Col < W_LIM);
  assign start  = active && (bus.Row == '0) && (bus.Col == '0);
  assign last   = active && (bus.Row == LAST_ROW) && (bus.Col == LAST_COL);
  assign fg     = (bus.GRAY2BW == FG_VALUE);

  // State register; a reset mid-frame drops back to IDLE so that frame is never published
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        state_q <= ST_IDLE;
    else if (bus.en) state_q <= state_d;
  end

  // Next state: arm on frame start, disarm after the last pixel
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SCAN;
      ST_SCAN: if (last)  state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: reload on frame start in any state, accumulate only while armed
  always_comb begin
    acc_load = start;
    acc_upd  = (state_q == ST_SCAN) && active && !start;
    pub_d    = (state_q == ST_SCAN) && last;
  end

  minmax_track u_row (
    .clk    (clk),
    .rst    (rst),
    .en_i   (bus.en),
    .load_i (acc_load),
    .upd_i  (acc_upd),
    .fg_i   (fg),
    .val_i  (bus.Row),
    .min_o  (rmin),
    .max_o  (rmax)
  );

  minmax_track u_col (
    .clk    (clk),
    .rst    (rst),
    .en_i   (bus.en),
    .load_i (acc_load),
    .upd_i  (acc_upd),
    .fg_i   (fg),
    .val_i  (bus.Col),
    .min_o  (cmin),
    .max_o  (cmax)
  );

  // Foreground count: reload on frame start, saturating increment otherwise
  always_comb begin
    cnt_d = cnt_q;
    if (acc_load)
      cnt_d = fg ? cnt_t'(1) : '0;
    else if (acc_upd && fg && (cnt_q != '1))
      cnt_d = cnt_q + cnt_t'(1);
  end

  // Count and publish-request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      pub_q <= 1'b0;
    end else if (bus.en) begin
      cnt_q <= cnt_d;
      pub_q <= pub_d;
    end
  end

  // Publish one clock after the last pixel; sparse frames keep the old box
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oRow_q   <= '0;
      oCol_q   <= '0;
      oCount_q <= '0;
      oValid_q <= 1'b0;
      oEmpty_q <= 1'b1;
    end else if (bus.en) begin
      oValid_q <= pub_q;
      if (pub_q) begin
        oCount_q <= cnt_q;
        if (cnt_q >= MIN_CNT) begin
          oRow_q   <= pack_bounds(rmax, rmin);
          oCol_q   <= pack_bounds(cmax, cmin);
          oEmpty_q <= 1'b0;
        end else begin
          oEmpty_q <= 1'b1;
        end
      end
    end
  end

  assign bus.oRow   = oRow_q;
  assign bus.oCol   = oCol_q;
  assign bus.oCount = oCount_q;
  assign bus.oValid = oValid_q;
  assign bus.oEmpty = oEmpty_q;

endmodule

// File: doc/bbox_detect.md
Name: bbox_detect

Overview:
- Upstream neighbour of the rectangle-drawing stage.
- Scans one binarised 640x480 frame, pixel by pixel, and tracks the min/max row and column of foreground pixels.
- At frame end it publishes the bounding box in the packed {max,min} format that the rectangle stage takes on iRow/iCol.
- The published box is held stable for the whole next frame, so the overlay always draws the previous frame's result.

Parameters:
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, active lines per frame.
- FG_VALUE, 10'd0, GRAY2BW value that counts as foreground (dark digit on white background).
- MIN_COUNT, 16, minimum foreground pixels per frame for a valid box; fewer means the frame is reported empty.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  pixel-sample enable; when low, no state changes
- Row  in  10  current scan row, from the shared address generator
- Col  in  10  current scan column
- GRAY2BW  in  10  binarised pixel, either 10'h3FF or 10'h000
- oRow  out  20  {row_max, row_min} of the last completed frame
- oCol  out  20  {col_max, col_min} of the last completed frame
- oValid  out  1  one-cycle pulse when oRow/oCol/oEmpty update
- oEmpty  out  1  last completed frame had fewer than MIN_COUNT foreground pixels
- oCount  out  19  foreground pixel count of the last completed frame

Behaviour:
- All sampling is on posedge clk with en=1. en=0 freezes every register, including armed.
- A sample is active only when Row<HEIGHT and Col<WIDTH; all other positions are blanking and ignored.
- Reset values:
  - oRow=0, oCol=0, oCount=0, oValid=0, oEmpty=1.
  - Accumulators: rmin=cmin=10'h3FF, rmax=cmax=0, cnt=0.
  - armed=0.
- State machine, 2 states:
  - IDLE (armed=0): waits for an active sample at Row=0,Col=0. That sample sets armed=1 and moves to SCAN.
  - SCAN: every active sample updates the accumulators.
  - Purpose: a frame interrupted by reset is never published.
- Frame start (Row=0,Col=0, active):
  - Accumulators reload from this pixel alone, discarding prior contents.
  - If foreground: rmin=rmax=0, cmin=cmax=0, cnt=1. Otherwise the reset values.
  - Accumulation does not also apply on this cycle.
- Accumulate (SCAN, foreground pixel):
  - rmin=min(rmin,Row), rmax=max(rmax,Row), cmin=min(cmin,Col), cmax=max(cmax,Col).
  - cnt saturates at 2^19-1.
- Frame end (active sample at Row=HEIGHT-1, Col=WIDTH-1, in SCAN):
  - Final accumulation includes this pixel.
  - On the next posedge, the outputs load and oValid=1 for exactly one cycle.
  - Latency: 1 clock after the last-pixel sample.
  - If total count >= MIN_COUNT: oRow={rmax,rmin}, oCol={cmax,cmin}, oEmpty=0.
  - Otherwise: oRow and oCol keep their previous values, oEmpty=1.
  - oCount is always updated.
  - State returns to IDLE and waits for the next frame start.
- Frame end in IDLE: ignored, no oValid.
- Last pixel and frame start in the same cycle: only possible with HEIGHT=WIDTH=1, which is unsupported.
- Min/max comparisons are unsigned 10-bit; the count is 19-bit (307200 < 2^19).
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package bbox_pkg holds:
  - COORD_W=10, CNT_W=19.
  - Default WIDTH/HEIGHT.
  - The packed-bounds layout {max[19:10], min[9:0]}, reused by the rectangle stage.
- One sub-module, minmax_track: a 10-bit running min/max register pair with load/update/enable. It is instantiated twice, once for rows and once for columns.

Test Plan:
- Solid block: foreground at rows 95..374, cols 225..407, full frame scanned -> oValid pulse 1 clk after (479,639); oRow={10'd374,10'd95}, oCol={10'd407,10'd225}, oCount=280*183=51240, oEmpty=0.
- Sparse frame: 5 foreground pixels, MIN_COUNT=16 -> oEmpty=1, oCount=5, oRow/oCol unchanged from the previous frame.
- Corner pixels: foreground only at (0,0) and (479,639) with MIN_COUNT=1 -> oRow={479,0}, oCol={639,0}. This exercises the frame-start reload and the last-pixel inclusion.
- Reset mid-frame: deassert rst at row 200, release, continue scanning -> no oValid at that frame's end; next full frame publishes correctly.
- en gating: hold en=0 for 50 cycles mid-frame while Row/Col keep moving -> those pixels are excluded; a foreground pixel present only during en=0 leaves the box unaffected.
- Blanking: foreground driven at Col=650 and Row=490 -> ignored; box and count unchanged.
